// File: rtl/pong_score_display.sv
// Purpose : two-player Pong score keeper with BCD counters, win detection and
//           active-low seven-segment drivers that blink the winner after game over.
// Latency : score updates on the edge sampling a point pulse; segments and
//           game_over/winner follow one edge later. Backpressure: none, pulses are
//           consumed every cycle while running and ignored once the game is over.
// Ports   : CLOCK2_50 clock, rst sync active-high reset, point_left/point_right
//           score pulses, clear new-game request, hex_left/hex_right segments
//           (digit k at [7k+6:7k], bit0=a .. bit6=g), game_over, winner (01 L, 10 R, 11 draw).
// Option  : define PONG_SCORE_ZERO_BLANK_EN to blank leading zero digits.
module pong_score_display #(
  parameter int DIGITS       = 2,
  parameter int WIN_SCORE    = 11,
  parameter int BLINK_CYCLES = 25000000
) (
  input  logic                CLOCK2_50,
  input  logic                rst,
  input  logic                point_left,
  input  logic                point_right,
  input  logic                clear,
  output logic [7*DIGITS-1:0] hex_left,
  output logic [7*DIGITS-1:0] hex_right,
  output logic                game_over,
  output logic [1:0]          winner
);

  localparam int SW = 4 * DIGITS;
  localparam int HW = 7 * DIGITS;
  localparam int CW = $clog2(BLINK_CYCLES);

  // Decimal constant to packed BCD, least significant digit in the low nibble.
  function automatic logic [SW-1:0] to_bcd(input int value);
    logic [SW-1:0] r;
    int            v;
    r = '0;
    v = value;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  localparam logic [SW-1:0] WIN_BCD = to_bcd(WIN_SCORE);

  generate
    if (DIGITS < 1 || DIGITS > 4) begin : g_bad_digits
      $error("pong_score_display: DIGITS must be 1..4");
    end
    if (WIN_SCORE < 1 || WIN_SCORE > (10 ** DIGITS) - 1) begin : g_bad_win
      $error("pong_score_display: WIN_SCORE out of range, counter would wrap");
    end
    if (BLINK_CYCLES < 2) begin : g_bad_blink
      $error("pong_score_display: BLINK_CYCLES must be at least 2");
    end
  endgenerate

  // Active-low segment pattern for one BCD digit; non-decimal codes blank.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  function automatic logic [HW-1:0] encode_score(input logic [SW-1:0] s);
    logic [HW-1:0] r;
`ifdef PONG_SCORE_ZERO_BLANK_EN
    logic          lead;
    lead = 1'b1;
`endif
    r = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      r[7*k +: 7] = seg7(s[4*k +: 4]);
`ifdef PONG_SCORE_ZERO_BLANK_EN
      // Blank while every digit from the top down to here is zero; digit 0 always shows.
      if (k != 0) begin
        lead = lead && (s[4*k +: 4] == 4'd0);
        if (lead) r[7*k +: 7] = 7'b1111111;
      end
`endif
    end
    return r;
  endfunction

  // BCD +1 with ripple carry; all-9s wraps to all-0s.
  function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] s);
    logic [SW-1:0] r;
    logic          carry;
    r     = s;
    carry = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (carry) begin
        if (s[4*k +: 4] == 4'd9) begin
          r[4*k +: 4] = 4'd0;
        end else begin
          r[4*k +: 4] = s[4*k +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  typedef enum logic {RUNNING, OVER} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] score_left_q, score_right_q;
  logic [HW-1:0] seg_left_q, seg_right_q;
  logic [CW-1:0] blink_cnt_q;
  logic          blink_off_q;
  logic [1:0]    winner_q;
  logic          sync_clr;
  logic          hit_left, hit_right;
  logic          count_en;

  assign sync_clr  = rst | clear;
  assign hit_left  = (score_left_q  == WIN_BCD);
  assign hit_right = (score_right_q == WIN_BCD);

  always_ff @(posedge CLOCK2_50) begin
    if (sync_clr) state_q <= RUNNING;
    else          state_q <= state_d;
  end

  // A score sitting at WIN_SCORE already freezes counting, so a pulse arriving
  // on the edge that moves us to OVER cannot push the score past the target.
  always_comb begin
    state_d  = state_q;
    count_en = 1'b0;
    case (state_q)
      RUNNING: begin
        if (hit_left || hit_right) state_d = OVER;
        else                       count_en = 1'b1;
      end
      OVER:    state_d = OVER;
      default: state_d = RUNNING;
    endcase
  end

  always_ff @(posedge CLOCK2_50) begin
    if (sync_clr) begin
      score_left_q  <= '0;
      score_right_q <= '0;
    end else if (count_en) begin
      if (point_left)  score_left_q  <= bcd_inc(score_left_q);
      if (point_right) score_right_q <= bcd_inc(score_right_q);
    end
  end

  always_ff @(posedge CLOCK2_50) begin
    if (sync_clr) begin
      winner_q <= 2'b00;
    end else if (state_q == RUNNING && state_d == OVER) begin
      winner_q <= {hit_right, hit_left};
    end
  end

  // Phase toggles when the counter wraps, so each half-period is BLINK_CYCLES long
  // and the first off phase begins BLINK_CYCLES cycles after entering OVER.
  always_ff @(posedge CLOCK2_50) begin
    if (sync_clr || state_q != OVER) begin
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
    end else if (blink_cnt_q == CW'(BLINK_CYCLES - 1)) begin
      blink_cnt_q <= '0;
      blink_off_q <= ~blink_off_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLOCK2_50) begin
    if (sync_clr) begin
      seg_left_q  <= encode_score('0);
      seg_right_q <= encode_score('0);
    end else begin
      seg_left_q  <= encode_score(score_left_q);
      seg_right_q <= encode_score(score_right_q);
    end
  end

  // Blanking is applied after the segment registers so it lines up with the phase
  // register and disappears on the same edge that clears the game.
  assign hex_left  = (blink_off_q && winner_q[0]) ? {HW{1'b1}} : seg_left_q;
  assign hex_right = (blink_off_q && winner_q[1]) ? {HW{1'b1}} : seg_right_q;
  assign game_over = (state_q == OVER);
  assign winner    = winner_q;

endmodule

// File: tb/tb_pong_score_display.sv
// Purpose : randomized and directed bench for pong_score_display against a
//           score-level reference model (integers, decimal digits, blink age).
// Ports   : drives CLOCK2_50, rst, point_left, point_right, clear; observes hex/game_over/winner.
module tb_pong_score_display;

  localparam int D = 2;
  localparam int W = 11;
  localparam int B = 4;

  logic          CLOCK2_50;
  logic          rst;
  logic          point_left;
  logic          point_right;
  logic          clear;
  logic [7*D-1:0] hex_left;
  logic [7*D-1:0] hex_right;
  logic          game_over;
  logic [1:0]    winner;

  pong_score_display #(.DIGITS(D), .WIN_SCORE(W), .BLINK_CYCLES(B)) dut (
    .CLOCK2_50  (CLOCK2_50),
    .rst        (rst),
    .point_left (point_left),
    .point_right(point_right),
    .clear      (clear),
    .hex_left   (hex_left),
    .hex_right  (hex_right),
    .game_over  (game_over),
    .winner     (winner)
  );

  initial CLOCK2_50 = 1'b0;
  always #10 CLOCK2_50 = ~CLOCK2_50;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: true scores, the scores currently on the display,
  // game-over flag, winner and number of cycles since game_over rose.
  int         ml, mr, shl, shr, age;
  bit         mover;
  logic [1:0] mwin;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7*D-1:0] exp_hex(input int v);
    logic [7*D-1:0] r;
    int             pw;
    r  = '0;
    pw = 1;
    for (int k = 0; k < D; k++) begin
      r[7*k +: 7] = seg_tab[(v / pw) % 10];
`ifdef PONG_SCORE_ZERO_BLANK_EN
      if (k > 0 && v < pw) r[7*k +: 7] = 7'b1111111;
`endif
      pw = pw * 10;
    end
    return r;
  endfunction

  task automatic step(input bit pl, input bit pr, input bit clr, input bit r);
    bit             off;
    logic [7*D-1:0] el, er;
    @(negedge CLOCK2_50);
    point_left  = pl;
    point_right = pr;
    clear       = clr;
    rst         = r;
    @(posedge CLOCK2_50);
    if (r || clr) begin
      ml = 0; mr = 0; shl = 0; shr = 0; mover = 0; mwin = 2'b00; age = 0;
    end else begin
      shl = ml;
      shr = mr;
      if (mover) begin
        age++;
      end else if (ml == W || mr == W) begin
        mover = 1;
        mwin  = {mr == W, ml == W};
        age   = 0;
      end else begin
        if (pl) ml++;
        if (pr) mr++;
      end
    end
    #1;
    off = mover && ((age / B) % 2 == 1);
    el  = (off && mwin[0]) ? '1 : exp_hex(shl);
    er  = (off && mwin[1]) ? '1 : exp_hex(shr);
    check_val("hex_left",  32'(hex_left),  32'(el));
    check_val("hex_right", 32'(hex_right), 32'(er));
    check_val("game_over", 32'(game_over), 32'(mover));
    check_val("winner",    32'(winner),    32'(mwin));
  endtask

  logic [7*D-1:0] zero_c, five_c, ten_c, three_c;
  int             guard;

  initial begin
    rst = 1'b1; clear = 1'b0; point_left = 1'b0; point_right = 1'b0;
    ml = 0; mr = 0; shl = 0; shr = 0; age = 0; mover = 0; mwin = 2'b00;
`ifdef PONG_SCORE_ZERO_BLANK_EN
    zero_c  = {7'b1111111, 7'b1000000};
    five_c  = {7'b1111111, 7'b0010010};
    three_c = {7'b1111111, 7'b0110000};
`else
    zero_c  = {7'b1000000, 7'b1000000};
    five_c  = {7'b1000000, 7'b0010010};
    three_c = {7'b1000000, 7'b0110000};
`endif
    ten_c = {7'b1111001, 7'b1000000};

    // Reset held three cycles, then released.
    repeat (3) step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    check_val("rst_hex_left",  32'(hex_left),  32'(zero_c));
    check_val("rst_hex_right", 32'(hex_right), 32'(zero_c));
    check_val("rst_game_over", 32'(game_over), 32'd0);
    check_val("rst_winner",    32'(winner),    32'd0);

    // Ten left points spaced four cycles apart: carry into the tens digit.
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      if (i == 4) check_val("five_hex_left", 32'(hex_left), 32'(five_c));
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
    end
    check_val("carry_hex_left",  32'(hex_left),  32'(ten_c));
    check_val("carry_hex_right", 32'(hex_right), 32'(zero_c));

    // Simultaneous points to a draw, then watch both displays blink.
    step(0, 0, 1, 0);
    for (int i = 0; i < 11; i++) step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    check_val("draw_game_over", 32'(game_over), 32'd1);
    check_val("draw_winner",    32'(winner),    32'd3);
    repeat (12) step(0, 0, 0, 0);

    // Left wins 11-3; a later right point is ignored; clear during an off phase.
    step(0, 0, 1, 0);
    repeat (3) step(0, 1, 0, 0);
    for (int i = 0; i < 11; i++) step(1, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0);
    check_val("win_winner", 32'(winner), 32'd1);
    step(0, 1, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    check_val("win_hex_right", 32'(hex_right), 32'(three_c));
    guard = 0;
    while (!(mover && ((age / B) % 2 == 1)) && guard < 20) begin
      step(0, 0, 0, 0);
      guard++;
    end
    check_val("blink_off_reached", 32'(guard < 20), 32'd1);
    check_val("blink_off_hex_left", 32'(hex_left), 32'h3fff);
    step(0, 0, 1, 0);
    check_val("clr_hex_left",  32'(hex_left),  32'(zero_c));
    check_val("clr_game_over", 32'(game_over), 32'd0);
    repeat (2) step(1, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0);

    // Random play with occasional clear and reset.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 79) == 0, $urandom_range(0, 249) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
